dmem_byte: RTL and testbench
============================

DMEM_BYTE -- requirements
Module: dmem_byte

Interface
REQ-001 Parameter DEPTH_LOG2, default 12, sets the word count to 2**DEPTH_LOG2 words of 32 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  1  access request, sampled on the clk rising edge.
REQ-005 we  input  1  1 = store, 0 = load; meaningful only with req.
REQ-006 addr  input  32  byte address.
REQ-007 funct3  input  3  RV32I load/store size and sign code.
REQ-008 wd  input  32  store data, right-aligned.
REQ-009 rd  output  32  load result, registered.
REQ-010 rd_valid  output  1  one-cycle pulse when rd updates.
REQ-011 err  output  1  one-cycle pulse for a rejected request.
REQ-012 busy  output  1  high while the block refuses requests.

Function
REQ-013 Word index is addr[DEPTH_LOG2+1:2], and the lane is addr[1:0]. Upper address bits are ignored, so accesses wrap modulo the depth.
REQ-014 A request is accepted only on a clk edge where req=1 and busy=0. Requests while busy are dropped: no write, no rd_valid, no err.
REQ-015 Loads have 1-cycle latency: rd and rd_valid=1 are registered on the edge that accepts the load, so both are visible in the cycle after req.
REQ-016 rd holds its value until the next valid load. rd_valid is 0 in every cycle without a fresh result.
REQ-017 Load decode by funct3:
- 000 LB: sign-extended byte at the lane.
- 001 LH: sign-extended half at lane 0 or 2.
- 010 LW: full word.
- 100 LBU: zero-extended byte.
- 101 LHU: zero-extended half.
REQ-018 Store decode by funct3:
- 000 SB writes wd[7:0] to the lane.
- 001 SH writes wd[15:0] to lanes 0-1 or 2-3.
- 010 SW writes all four lanes.
- Unselected lanes are unchanged.
REQ-019 A request is an error when any of the following holds:
- halfword access with addr[0]=1;
- word access with addr[1:0]≠00;
- any funct3 not listed in REQ-017/REQ-018.
REQ-020 An error pulses err in the cycle after req. It performs no write, leaves rd unchanged and does not assert rd_valid.
REQ-021 A store followed by a load to the same word on the next edge returns the stored data.
REQ-022 Control FSM has two states, CLEAR and READY; busy=1 exactly in CLEAR.
REQ-023 In CLEAR, the block writes zero to word ctr every cycle and increments ctr.
REQ-024 CLEAR→READY happens on the edge that writes word 2**DEPTH_LOG2-1. READY has no exit except reset.

Reset
REQ-025 While rst=1, the block holds rd=0, rd_valid=0, err=0 and ctr=0.
REQ-026 The state during rst=1 is CLEAR when DMEM_CLEAR_EN is defined, otherwise READY.
REQ-027 Memory contents are not reset directly.
REQ-028 Reset asserted mid-clear restarts the clear from word 0.
REQ-029 Reset asserted with a load in flight suppresses its rd_valid.

Configuration
REQ-030 The feature is controlled by macro DMEM_CLEAR_EN.
- Defined: post-reset zero-fill per REQ-022–REQ-024; busy is high for 2**DEPTH_LOG2 cycles after rst falls.
- Undefined: no CLEAR state and no ctr; busy is tied to 0; initial memory contents are undefined.

Structure
REQ-031 Shared package dmem_pkg holds the following:
- funct3 encodings (LB/LH/LW/LBU/LHU, SB/SH/SW);
- FSM state encoding;
- DATA_W=32.
REQ-032 Combinational sub-module dmem_lane_align performs lane extraction and sign/zero extension for loads, plus lane write-mask generation for stores.

Verification
REQ-033 With DMEM_CLEAR_EN, DEPTH_LOG2=4 and rst pulsed:
- busy stays high for exactly 16 cycles, and req during that time gets no response;
- after busy falls, LW of addr 0x3C returns 0x00000000 with rd_valid 1 cycle later.
REQ-034 Store/load round trip:
- SW 0x80FF7F01 at 0x10, then LB 0x13 → rd=0xFFFFFF80.
- LBU 0x13 → 0x00000080.
- LH 0x10 → 0x00007F01.
- LHU 0x12 → 0x000080FF.
REQ-035 Lane merge: SW 0x11223344 at 0x20, then SB 0xAA at 0x21, then SH 0xBEEF at 0x22, then LW 0x20 → 0xBEEFAA44.
REQ-036 Error cases:
- LW at 0x06 → err pulse, no rd_valid, rd unchanged.
- SH at 0x05 → err, and a following LW at 0x04 shows the memory unchanged.
- funct3=011 → err.
REQ-037 Wrap-around: with DEPTH_LOG2=4, SW 0xDEADBEEF at 0x40 then LW 0x00 → 0xDEADBEEF.
REQ-038 Reset interruptions:
- rst asserted at clear word 7 → busy is high again for a full 16 cycles after release.
- rst asserted in the cycle after a load req → no rd_valid pulse.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable data memory.
//   DATA_W      : data word width (32)
//   F3_*        : RV32I funct3 codes for loads and stores
//   state_t     : control FSM states (CLEAR zero-fills memory, READY serves requests)
package dmem_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for dmem_byte.
//   funct3    : RV32I size/sign code
//   we        : 1 = store, 0 = load
//   lane      : byte lane addr[1:0]
//   word      : memory word at the addressed index
//   wd        : right-aligned store data
//   load_data : extracted and extended load result
//   wmask     : per-byte write enable for stores (zero when bad)
//   wdata     : store data replicated onto every lane it may target
//   bad       : misaligned access or unsupported funct3
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic              we,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] load_data,
  output logic [3:0]        wmask,
  output logic [DATA_W-1:0] wdata,
  output logic              bad
);

  function automatic logic [DATA_W-1:0] sext8(input logic signed [7:0] b);
    logic signed [DATA_W-1:0] r;
    r = b;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic signed [15:0] h);
    logic signed [DATA_W-1:0] r;
    r = h;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] zext8(input logic [7:0] b);
    return {{(DATA_W-8){1'b0}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] zext16(input logic [15:0] h);
    return {{(DATA_W-16){1'b0}}, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_data = '0;
    wmask     = 4'b0000;
    wdata     = wd;
    bad       = 1'b0;
    if (!we) begin
      case (funct3)
        F3_LB:   load_data = sext8(byte_sel);
        F3_LH:   begin load_data = sext16(half_sel); bad = lane[0]; end
        F3_LW:   begin load_data = word;             bad = |lane;   end
        F3_LBU:  load_data = zext8(byte_sel);
        F3_LHU:  begin load_data = zext16(half_sel); bad = lane[0]; end
        default: bad = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_SB: begin
          wmask = 4'b0001 << lane;
          wdata = {4{wd[7:0]}};
        end
        F3_SH: begin
          wmask = lane[1] ? 4'b1100 : 4'b0011;
          wdata = {2{wd[15:0]}};
          bad   = lane[0];
        end
        F3_SW: begin
          wmask = 4'b1111;
          bad   = |lane;
        end
        default: bad = 1'b1;
      endcase
    end
    if (bad) wmask = 4'b0000;
  end

endmodule

// File: rtl/dmem_byte.sv
// Byte-addressable RV32I data memory, 2**DEPTH_LOG2 words of 32 bits.
//   clk, rst  : clock, asynchronous active-high reset
//   req, we   : request strobe, 1 = store / 0 = load
//   addr      : byte address (upper bits ignored, wraps modulo depth)
//   funct3    : RV32I load/store size and sign code
//   wd        : right-aligned store data
//   rd        : registered load result, held until the next good load
//   rd_valid  : one-cycle pulse when rd updates
//   err       : one-cycle pulse for a rejected (misaligned/illegal) request
//   busy      : high while requests are refused
// Build option: define DMEM_CLEAR_EN to zero-fill the memory after every reset
// (busy for 2**DEPTH_LOG2 cycles); otherwise busy is tied low.
module dmem_byte
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [2:0]        funct3,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  output logic              rd_valid,
  output logic              err,
  output logic              busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx_p0;
  logic [1:0]            lane_p0;
  logic [DATA_W-1:0]     word_p0;
  logic [DATA_W-1:0]     load_p0;
  logic [DATA_W-1:0]     wdata_p0;
  logic [3:0]            wmask_p0;
  logic                  bad_p0;
  logic                  acc_p0;
  logic                  ld_ok_p0;
  logic                  st_ok_p0;
  logic                  unused_addr;

  // Stage p0: decode the incoming request against the current word
  assign idx_p0      = addr[DEPTH_LOG2+1:2];
  assign lane_p0     = addr[1:0];
  assign word_p0     = mem[idx_p0];
  assign unused_addr = ^addr[31:DEPTH_LOG2+2];

  dmem_lane_align u_align (
    .funct3    (funct3),
    .we        (we),
    .lane      (lane_p0),
    .word      (word_p0),
    .wd        (wd),
    .load_data (load_p0),
    .wmask     (wmask_p0),
    .wdata     (wdata_p0),
    .bad       (bad_p0)
  );

  assign acc_p0   = req & ~busy;
  assign ld_ok_p0 = acc_p0 & ~we & ~bad_p0;
  assign st_ok_p0 = acc_p0 &  we & ~bad_p0;

`ifdef DMEM_CLEAR_EN
  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] ctr, ctr_nxt;
  logic                  clr_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
      ctr   <= '0;
    end else begin
      state <= state_nxt;
      ctr   <= ctr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ctr_nxt   = ctr;
    busy      = 1'b0;
    clr_we    = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy    = 1'b1;
        clr_we  = 1'b1;
        ctr_nxt = ctr + DEPTH_LOG2'(1);
        if (ctr == '1) state_nxt = ST_READY;
      end
      default: ;
    endcase
  end

  // Clear and stores never coincide: busy blocks every store during CLEAR.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[ctr] <= '0;
    end else if (st_ok_p0) begin
      for (int i = 0; i < 4; i++)
        if (wmask_p0[i]) mem[idx_p0][i*8 +: 8] <= wdata_p0[i*8 +: 8];
    end
  end
`else
  assign busy = 1'b0;

  always_ff @(posedge clk) begin
    if (st_ok_p0) begin
      for (int i = 0; i < 4; i++)
        if (wmask_p0[i]) mem[idx_p0][i*8 +: 8] <= wdata_p0[i*8 +: 8];
    end
  end
`endif

  // Stage p1: registered load result and status pulses
  logic [DATA_W-1:0] rd_p1;
  logic              vld_p1;
  logic              err_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_p1  <= '0;
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      vld_p1 <= ld_ok_p0;
      err_p1 <= acc_p0 & bad_p0;
      if (ld_ok_p0) rd_p1 <= load_p0;
    end
  end

  assign rd       = rd_p1;
  assign rd_valid = vld_p1;
  assign err      = err_p1;

endmodule

// File: tb/tb_dmem_byte.sv
module tb_dmem_byte;

  localparam int DL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [2:0]  funct3;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        rd_valid;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_byte #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
    .funct3(funct3), .wd(wd), .rd(rd), .rd_valid(rd_valid),
    .err(err), .busy(busy)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_vld;
    logic        exp_err;
  } vec_t;

  vec_t vt [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic exp_busy);
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_rd", rd, 32'h0);
    chk("reset_rd_valid", {31'b0, rd_valid}, 32'h0);
    chk("reset_err", {31'b0, err}, 32'h0);
    chk("reset_busy", {31'b0, busy}, {31'b0, exp_busy});
    rst = 1'b0;
  endtask

  // Counts rising edges from reset release until busy is seen low, with a
  // load held on req throughout to confirm it is ignored.
  task automatic count_busy(output int n, output logic responded);
    n = 0;
    responded = 1'b0;
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h0; wd = 32'h0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (rd_valid || err) responded = 1'b1;
    end while (busy && n < 100);
    req = 1'b0;
  endtask

  initial begin
    int   n;
    logic resp;

    rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; funct3 = '0; wd = '0;

    vt[0]  = '{1'b1, 3'b010, 32'h10, 32'h80FF7F01, 32'h00000000, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 3'b100, 32'h13, 32'h0,        32'h00000080, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 3'b001, 32'h10, 32'h0,        32'h00007F01, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 3'b101, 32'h12, 32'h0,        32'h000080FF, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 3'b010, 32'h20, 32'h11223344, 32'h000080FF, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 3'b000, 32'h21, 32'h000000AA, 32'h000080FF, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 3'b001, 32'h22, 32'h0000BEEF, 32'h000080FF, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 3'b010, 32'h20, 32'h0,        32'hBEEFAA44, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 3'b010, 32'h06, 32'h0,        32'hBEEFAA44, 1'b0, 1'b1};
    vt[10] = '{1'b1, 3'b010, 32'h04, 32'h12345678, 32'hBEEFAA44, 1'b0, 1'b0};
    vt[11] = '{1'b1, 3'b001, 32'h05, 32'hFFFFFFFF, 32'hBEEFAA44, 1'b0, 1'b1};
    vt[12] = '{1'b0, 3'b010, 32'h04, 32'h0,        32'h12345678, 1'b1, 1'b0};
    vt[13] = '{1'b0, 3'b011, 32'h00, 32'h0,        32'h12345678, 1'b0, 1'b1};
    vt[14] = '{1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 32'h12345678, 1'b0, 1'b0};
    vt[15] = '{1'b0, 3'b010, 32'h00, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vt[16] = '{1'b0, 3'b000, 32'h22, 32'h0,        32'hFFFFFFEF, 1'b1, 1'b0};
    vt[17] = '{1'b0, 3'b001, 32'h22, 32'h0,        32'hFFFFBEEF, 1'b1, 1'b0};
    vt[18] = '{1'b0, 3'b100, 32'h20, 32'h0,        32'h00000044, 1'b1, 1'b0};
    vt[19] = '{1'b1, 3'b010, 32'h08, 32'h00C0FFEE, 32'h00000044, 1'b0, 1'b0};
    vt[20] = '{1'b1, 3'b011, 32'h08, 32'hFFFFFFFF, 32'h00000044, 1'b0, 1'b1};
    vt[21] = '{1'b1, 3'b100, 32'h08, 32'hFFFFFFFF, 32'h00000044, 1'b0, 1'b1};
    vt[22] = '{1'b0, 3'b110, 32'h00, 32'h0,        32'h00000044, 1'b0, 1'b1};
    vt[23] = '{1'b0, 3'b010, 32'h08, 32'h0,        32'h00C0FFEE, 1'b1, 1'b0};
    vt[24] = '{1'b0, 3'b101, 32'h0A, 32'h0,        32'h000000C0, 1'b1, 1'b0};
    vt[25] = '{1'b0, 3'b001, 32'h0B, 32'h0,        32'h000000C0, 1'b0, 1'b1};

`ifdef DMEM_CLEAR_EN
    do_reset(1'b1);
    count_busy(n, resp);
    chk("clear_cycles", n, 16);
    chk("clear_no_response", {31'b0, resp}, 32'h0);

    // Interrupt the clear at word 7 and check it starts over.
    do_reset(1'b1);
    repeat (7) @(posedge clk);
    #1;
    chk("clear_mid_busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy(n, resp);
    chk("reclear_cycles", n, 16);
    chk("reclear_no_response", {31'b0, resp}, 32'h0);

    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h3C;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("cleared_lw_rd", rd, 32'h0);
    chk("cleared_lw_vld", {31'b0, rd_valid}, 32'h1);
    rd_valid_low_check: begin
      @(posedge clk);
      #1;
      chk("cleared_vld_pulse", {31'b0, rd_valid}, 32'h0);
    end
`else
    do_reset(1'b0);
`endif

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      req = 1'b1; we = vt[i].we; funct3 = vt[i].f3; addr = vt[i].addr; wd = vt[i].wd;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_vld", i), {31'b0, rd_valid}, {31'b0, vt[i].exp_vld});
      chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vt[i].exp_err});
    end
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_vld", {31'b0, rd_valid}, 32'h0);
    chk("idle_err", {31'b0, err}, 32'h0);
    chk("idle_rd_hold", rd, 32'h000000C0);

    // Reset in the cycle after a load request drops its result.
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h10;
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 1'b0;
    #1;
    chk("inflight_vld", {31'b0, rd_valid}, 32'h0);
    chk("inflight_rd", rd, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_vld", {31'b0, rd_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
